alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Sequential issue/capture front end for the 32-bit ALU. It accepts one decoded instruction per transaction through a valid/ready handshake and translates the ALUOp/funct fields into the ALU's 4-bit control code. It drives the ALU operand and control ports from registers, captures the ALU result and zero flag one cycle later, and presents a registered result with branch resolution on a valid/ready output. It sits between the decode stage and the ALU, acting as the producer of the ALU's control interface.

## Interface

- `WIDTH`, 32, datapath width of operands and result
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `in_valid`  in  1  request present
- `in_ready`  out  1  block can accept a request
- `alu_op`  in  2  00 = load/store add, 01 = branch compare, 10 = arithmetic/logic, 11 = reserved
- `funct3`  in  3  instruction funct3
- `funct7b5`  in  1  instruction bit 30
- `is_rtype`  in  1  1 = register-register, 0 = immediate
- `op_a`, `op_b`  in  WIDTH  operands
- `alu_control`  out  4  control code to the ALU
- `alu_a`, `alu_b`  out  WIDTH  operands to the ALU
- `alu_c`  in  WIDTH  ALU result
- `alu_zero`  in  1  ALU zero flag
- `out_valid`  out  1  result available
- `out_ready`  in  1  consumer accepts the result
- `result`  out  WIDTH  captured ALU result
- `zero`  out  1  captured zero flag
- `branch_taken`  out  1  branch resolution
- `illegal`  out  1  unsupported operation

## Operation

**ALU control codes**
- AND = 0000
- OR = 0001
- ADD = 0010
- XOR = 0011
- SLL = 0100
- SRL = 0101
- SUB = 0110
- SRA = 0111
- Illegal = 1111 (the ALU default case returns c = 0, zero = 1)

**Decode by `alu_op`**
- 00 → ADD.
- 01 → SUB.
  - funct3 000 (BEQ): `branch_taken` = `alu_zero`.
  - funct3 001 (BNE): `branch_taken` = !`alu_zero`.
  - Any other funct3 → illegal.
- 10 → decode by funct3:
  - 000: SUB if `is_rtype` && `funct7b5`, else ADD.
  - 001: SLL.
  - 100: XOR.
  - 101: SRA if `funct7b5`, else SRL.
  - 110: OR.
  - 111: AND.
  - 010 and 011 → illegal.
- 11 → illegal.

**Illegal requests**
- Still complete a full transaction.
- `alu_control` = 1111.
- `result`/`zero` are captured from the ALU unchanged.
- `illegal` = 1 and `branch_taken` = 0.

**Operands**
- `op_a`/`op_b` are registered unchanged; the ALU uses `b[4:0]` for shifts.
- `branch_taken` is 0 for every `alu_op` other than 01.

**FSM states**
- IDLE: `in_ready` = 1. On `in_valid`, register operands, the decoded control code and the branch/illegal flags, then go to EXEC.
- EXEC: the ALU ports are driven from registers. At the end of the cycle, capture `alu_c`, `alu_zero`, compute `branch_taken`, then go to DONE.
- DONE: `out_valid` = 1. On `out_ready`, go to IDLE; otherwise hold.

**Handshake and stability**
- `in_ready` is high only in IDLE. There is no accept in DONE, even if `out_ready` is high in the same cycle.
- `alu_control`, `alu_a`, `alu_b` always reflect the last accepted request and stay stable outside accept edges.
- `result`, `zero`, `branch_taken`, `illegal` change only at the EXEC→DONE edge and are held while `out_valid` && !`out_ready`.

## Timing

- **Accept:** request accepted at rising edge k (IDLE, `in_valid` = 1). ALU inputs are valid from edge k.
- **Capture:** result captured at edge k+1. `out_valid` is high from edge k+1.
- **Return:** with `out_ready` = 1, the block returns to IDLE at edge k+2. Maximum throughput is one request per 3 cycles.
- **ALU path:** the ALU is combinational and must settle within one clock.
- **Reset values** (asynchronous on `rst_n` low, applies in any state including mid-transaction; any in-flight request is dropped):
  - state = IDLE.
  - `in_ready` = 1 once `rst_n` is high.
  - `out_valid` = 0.
  - `alu_control` = 0000.
  - `alu_a`, `alu_b`, `result` = 0.
  - `zero`, `branch_taken`, `illegal` = 0.
- **Release:** first accept is possible at the first rising edge after `rst_n` deasserts.

## Test plan

- **R-type SUB:** `alu_op` = 10, funct3 = 000, `funct7b5` = 1, `is_rtype` = 1, a = 5, b = 5 → `alu_control` = 0110, `result` = 0, `zero` = 1, `out_valid` one edge after `alu_control` updates.
- **I-type SRAI vs SRLI:** `alu_op` = 10, funct3 = 101, `funct7b5` = 1, a = 0x80000000, b = 0x404 → `alu_control` = 0111, `result` = 0xF8000000. Same request with `funct7b5` = 0 → 0101, `result` = 0x08000000.
- **Branches:** BEQ with a = 7, b = 7 → `branch_taken` = 1. BNE with a = 7, b = 7 → `branch_taken` = 0. BNE with a = 7, b = 3 → `branch_taken` = 1, `result` = 4.
- **Illegal:** `alu_op` = 10, funct3 = 010 → `alu_control` = 1111, `illegal` = 1, `result` = 0, `zero` = 1, `branch_taken` = 0. `alu_op` = 11 gives the same response.
- **Backpressure:** hold `out_ready` = 0 for 5 cycles while `in_valid` stays 1 with a new request.
  - Outputs stay stable and `in_ready` stays 0.
  - After `out_ready` = 1 for one cycle, the new request is accepted on the next edge.
- **Reset mid-operation:** assert `rst_n` low during EXEC and again during DONE.
  - All outputs go to their reset values immediately, without waiting for a clock edge.
  - After release, an ADD of 1 + 2 returns 3.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue/capture front end for the 32-bit ALU.
// Accepts one decoded instruction per transaction (valid/ready), decodes
// alu_op/funct3/funct7b5/is_rtype into the ALU 4-bit control code, drives the
// ALU from registers, captures result/zero one cycle later and presents them
// with branch resolution and an illegal flag on a valid/ready output.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   in_valid/in_ready               request handshake
//   alu_op, funct3, funct7b5,
//   is_rtype, op_a, op_b            decoded request fields
//   alu_control, alu_a, alu_b       registered ALU drive
//   alu_c, alu_zero                 combinational ALU response
//   out_valid/out_ready             result handshake
//   result, zero, branch_taken,
//   illegal                         captured response
module alu_issue_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_op,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             is_rtype,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [3:0]       alu_control,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_c,
    input  logic             alu_zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             branch_taken,
    output logic             illegal
);

    localparam int unsigned CW = 4;

    localparam logic [CW-1:0] CTRL_AND = 4'b0000;
    localparam logic [CW-1:0] CTRL_OR  = 4'b0001;
    localparam logic [CW-1:0] CTRL_ADD = 4'b0010;
    localparam logic [CW-1:0] CTRL_XOR = 4'b0011;
    localparam logic [CW-1:0] CTRL_SLL = 4'b0100;
    localparam logic [CW-1:0] CTRL_SRL = 4'b0101;
    localparam logic [CW-1:0] CTRL_SUB = 4'b0110;
    localparam logic [CW-1:0] CTRL_SRA = 4'b0111;
    localparam logic [CW-1:0] CTRL_ILL = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic          accept;
    logic [CW-1:0] dec_ctrl;
    logic          dec_beq, dec_bne, dec_ill;
    logic          beq_q, bne_q, ill_q;

    // Instruction decode into ALU control code and branch/illegal flags
    always_comb begin
        dec_ctrl = CTRL_ILL;
        dec_beq  = 1'b0;
        dec_bne  = 1'b0;
        dec_ill  = 1'b0;
        unique case (alu_op)
            2'b00: dec_ctrl = CTRL_ADD;
            2'b01: begin
                unique case (funct3)
                    3'b000: begin
                        dec_ctrl = CTRL_SUB;
                        dec_beq  = 1'b1;
                    end
                    3'b001: begin
                        dec_ctrl = CTRL_SUB;
                        dec_bne  = 1'b1;
                    end
                    default: dec_ill = 1'b1;
                endcase
            end
            2'b10: begin
                unique case (funct3)
                    3'b000:  dec_ctrl = (is_rtype && funct7b5) ? CTRL_SUB : CTRL_ADD;
                    3'b001:  dec_ctrl = CTRL_SLL;
                    3'b100:  dec_ctrl = CTRL_XOR;
                    3'b101:  dec_ctrl = funct7b5 ? CTRL_SRA : CTRL_SRL;
                    3'b110:  dec_ctrl = CTRL_OR;
                    3'b111:  dec_ctrl = CTRL_AND;
                    default: dec_ill  = 1'b1;
                endcase
            end
            default: dec_ill = 1'b1;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (in_valid) state_nxt = EXEC;
            EXEC:    state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    assign accept = in_valid && (state == IDLE);

    // ALU drive registers, loaded only on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_control <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            beq_q       <= 1'b0;
            bne_q       <= 1'b0;
            ill_q       <= 1'b0;
        end else if (accept) begin
            alu_control <= dec_ctrl;
            alu_a       <= op_a;
            alu_b       <= op_b;
            beq_q       <= dec_beq;
            bne_q       <= dec_bne;
            ill_q       <= dec_ill;
        end
    end

    // Response capture at the EXEC->DONE edge; held otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result       <= '0;
            zero         <= 1'b0;
            branch_taken <= 1'b0;
            illegal      <= 1'b0;
        end else if (state == EXEC) begin
            result       <= alu_c;
            zero         <= alu_zero;
            branch_taken <= (beq_q && alu_zero) || (bne_q && !alu_zero);
            illegal      <= ill_q;
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl: behavioural ALU on the control port, a
// specification-level reference model, directed and randomized transactions.
module tb_alu_issue_ctrl;

    localparam int unsigned WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       alu_op;
    logic [2:0]       funct3;
    logic             funct7b5;
    logic             is_rtype;
    logic [WIDTH-1:0] op_a, op_b;
    logic [3:0]       alu_control;
    logic [WIDTH-1:0] alu_a, alu_b;
    logic [WIDTH-1:0] alu_c;
    logic             alu_zero;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             branch_taken;
    logic             illegal;

    int checks = 0;
    int errors = 0;

    alu_issue_ctrl #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .funct3(funct3), .funct7b5(funct7b5), .is_rtype(is_rtype),
        .op_a(op_a), .op_b(op_b),
        .alu_control(alu_control), .alu_a(alu_a), .alu_b(alu_b),
        .alu_c(alu_c), .alu_zero(alu_zero),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .branch_taken(branch_taken), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational ALU seen by the DUT
    always_comb begin
        case (alu_control)
            4'b0000: alu_c = alu_a & alu_b;
            4'b0001: alu_c = alu_a | alu_b;
            4'b0010: alu_c = alu_a + alu_b;
            4'b0011: alu_c = alu_a ^ alu_b;
            4'b0100: alu_c = alu_a << alu_b[4:0];
            4'b0101: alu_c = alu_a >> alu_b[4:0];
            4'b0110: alu_c = alu_a - alu_b;
            4'b0111: alu_c = WIDTH'($signed(alu_a) >>> alu_b[4:0]);
            default: alu_c = '0;
        endcase
        alu_zero = (alu_c == '0);
    end

    typedef struct {
        logic [3:0]  ctrl;
        logic [31:0] res;
        logic        zf;
        logic        br;
        logic        ill;
    } exp_t;

    // Reference: what the instruction means, independent of DUT internals
    function automatic exp_t ref_model(input logic [1:0] op, input logic [2:0] f3,
                                       input logic f7, input logic rt,
                                       input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int unsigned sh;
        sh    = int'(b[4:0]);
        e.ctrl = 4'hF; e.res = 32'd0; e.br = 1'b0; e.ill = 1'b1;
        if (op == 2'd0) begin
            e.ctrl = 4'd2; e.res = a + b; e.ill = 1'b0;
        end else if (op == 2'd1 && (f3 == 3'd0 || f3 == 3'd1)) begin
            e.ctrl = 4'd6; e.res = a - b; e.ill = 1'b0;
            e.br   = (f3 == 3'd0) ? (a == b) : (a != b);
        end else if (op == 2'd2 && f3 != 3'd2 && f3 != 3'd3) begin
            e.ill = 1'b0;
            if (f3 == 3'd0 && rt && f7) begin e.ctrl = 4'd6; e.res = a - b; end
            else if (f3 == 3'd0)        begin e.ctrl = 4'd2; e.res = a + b; end
            else if (f3 == 3'd1)        begin e.ctrl = 4'd4; e.res = a << sh; end
            else if (f3 == 3'd4)        begin e.ctrl = 4'd3; e.res = a ^ b; end
            else if (f3 == 3'd5 && f7)  begin
                e.ctrl = 4'd7;
                e.res  = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
            end
            else if (f3 == 3'd5)        begin e.ctrl = 4'd5; e.res = a >> sh; end
            else if (f3 == 3'd6)        begin e.ctrl = 4'd1; e.res = a | b; end
            else                        begin e.ctrl = 4'd0; e.res = a & b; end
        end
        e.zf = (e.res == 32'd0);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                         input logic rt, input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1; alu_op = op; funct3 = f3; funct7b5 = f7; is_rtype = rt;
        op_a = a; op_b = b;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready_timeout", 32'(in_ready), 32'd1);
    endtask

    // Full transaction with 'stall' cycles of out_ready low in DONE
    task automatic run_txn(input string tag, input logic [1:0] op, input logic [2:0] f3,
                           input logic f7, input logic rt, input logic [31:0] a,
                           input logic [31:0] b, input int stall);
        exp_t e;
        e = ref_model(op, f3, f7, rt, a, b);
        wait_ready();
        drive(op, f3, f7, rt, a, b);
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, ".ctrl"}, 32'(alu_control), 32'(e.ctrl));
        check({tag, ".alu_a"}, alu_a, a);
        check({tag, ".alu_b"}, alu_b, b);
        check({tag, ".exec_ov"}, 32'(out_valid), 32'd0);
        check({tag, ".exec_ir"}, 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        check({tag, ".ov"}, 32'(out_valid), 32'd1);
        check({tag, ".res"}, result, e.res);
        check({tag, ".zero"}, 32'(zero), 32'(e.zf));
        check({tag, ".br"}, 32'(branch_taken), 32'(e.br));
        check({tag, ".ill"}, 32'(illegal), 32'(e.ill));
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check({tag, ".hold_ov"}, 32'(out_valid), 32'd1);
            check({tag, ".hold_res"}, result, e.res);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, ".ret_ov"}, 32'(out_valid), 32'd0);
        check({tag, ".ret_ir"}, 32'(in_ready), 32'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".ov"}, 32'(out_valid), 32'd0);
        check({tag, ".ctrl"}, 32'(alu_control), 32'd0);
        check({tag, ".alu_a"}, alu_a, 32'd0);
        check({tag, ".alu_b"}, alu_b, 32'd0);
        check({tag, ".res"}, result, 32'd0);
        check({tag, ".zero"}, 32'(zero), 32'd0);
        check({tag, ".br"}, 32'(branch_taken), 32'd0);
        check({tag, ".ill"}, 32'(illegal), 32'd0);
    endtask

    initial begin
        logic [1:0]  rop;
        logic [2:0]  rf3;
        logic [31:0] ra, rb;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        alu_op = '0; funct3 = '0; funct7b5 = 1'b0; is_rtype = 1'b0;
        op_a = '0; op_b = '0;
        #3;
        check_reset_vals("por");
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        check("por.ir", 32'(in_ready), 32'd1);

        // Directed cases
        run_txn("rsub",  2'b10, 3'b000, 1'b1, 1'b1, 32'd5, 32'd5, 0);
        run_txn("srai",  2'b10, 3'b101, 1'b1, 1'b0, 32'h8000_0000, 32'h404, 0);
        run_txn("srli",  2'b10, 3'b101, 1'b0, 1'b0, 32'h8000_0000, 32'h404, 0);
        run_txn("beq",   2'b01, 3'b000, 1'b0, 1'b1, 32'd7, 32'd7, 0);
        run_txn("bne_e", 2'b01, 3'b001, 1'b0, 1'b1, 32'd7, 32'd7, 0);
        run_txn("bne_n", 2'b01, 3'b001, 1'b0, 1'b1, 32'd7, 32'd3, 0);
        run_txn("ill10", 2'b10, 3'b010, 1'b0, 1'b1, 32'd9, 32'd4, 1);
        run_txn("ill11", 2'b11, 3'b000, 1'b0, 1'b1, 32'd9, 32'd4, 0);
        run_txn("illbr", 2'b01, 3'b100, 1'b0, 1'b1, 32'd9, 32'd9, 0);
        run_txn("addi",  2'b10, 3'b000, 1'b1, 1'b0, 32'd9, 32'd4, 0);

        // Backpressure: new request waits while DONE is stalled
        wait_ready();
        drive(2'b00, 3'b000, 1'b0, 1'b0, 32'd10, 32'd20);
        @(posedge clk); #1;
        drive(2'b10, 3'b100, 1'b0, 1'b1, 32'hF0F0_0000, 32'h0FF0_0000);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            check("bp.ir", 32'(in_ready), 32'd0);
            check("bp.ov", 32'(out_valid), 32'd1);
            check("bp.ctrl", 32'(alu_control), 32'd2);
            check("bp.res", result, 32'd30);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp.idle_ir", 32'(in_ready), 32'd1);
        check("bp.idle_ctrl", 32'(alu_control), 32'd2);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp.acc_ctrl", 32'(alu_control), 32'd3);
        check("bp.acc_ir", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        check("bp.res2", result, 32'hFF00_0000);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset in EXEC
        wait_ready();
        drive(2'b00, 3'b000, 1'b0, 1'b0, 32'd5, 32'd6);
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_vals("rst_exec");
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_exec.ir", 32'(in_ready), 32'd1);
        check("rst_exec.ov", 32'(out_valid), 32'd0);

        // Reset in DONE
        drive(2'b00, 3'b000, 1'b0, 1'b0, 32'd5, 32'd6);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("rst_done.pre", result, 32'd11);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("rst_done");
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_done.ir", 32'(in_ready), 32'd1);
        run_txn("post_rst", 2'b00, 3'b000, 1'b0, 1'b0, 32'd1, 32'd2, 0);

        // Randomized transactions
        for (int i = 0; i < 60; i++) begin
            rop = 2'($urandom_range(0, 3));
            rf3 = 3'($urandom_range(0, 7));
            if (rop == 2'b01 && $urandom_range(0, 2) != 0) rf3 = 3'($urandom_range(0, 1));
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? ra : 32'($urandom);
            run_txn("rand", rop, rf3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    ra, rb, int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
